// File: rtl/mrnaiso_pkg.sv
// Shared constants for the mRNA-isolation sequencer: state codes, valve bit
// assignments, per-state valve masks, pump pattern and duration indices.
package mrnaiso_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE    = 4'd0;
    localparam state_t ST_BEAD    = 4'd1;
    localparam state_t ST_CELL    = 4'd2;
    localparam state_t ST_LYSIS   = 4'd3;
    localparam state_t ST_MIX     = 4'd4;
    localparam state_t ST_SEP     = 4'd5;
    localparam state_t ST_COLLECT = 4'd6;
    localparam state_t ST_FLUSH   = 4'd7;
    localparam state_t ST_DONE    = 4'd8;

    localparam int CTRL_W  = 13;
    localparam int NUM_DUR = 6;

    localparam int CTRL_BEADS       = 0;
    localparam int CTRL_CELLS       = 1;
    localparam int CTRL_CELL_OUT    = 2;
    localparam int CTRL_COLLECT     = 3;
    localparam int CTRL_LYSIS_IN    = 4;
    localparam int CTRL_CHAMBER_OUT = 5;
    localparam int CTRL_MAG_IN      = 6;
    localparam int CTRL_MIX_ISO     = 7;
    localparam int CTRL_SEP_WASTE   = 8;
    localparam int CTRL_SEP_IN      = 9;
    localparam int CTRL_BEAD_OUT    = 10;
    localparam int CTRL_BEAD_VENT   = 11;
    localparam int CTRL_LYSIS_OUT   = 12;

    localparam logic [CTRL_W-1:0] MASK_BEAD    = CTRL_W'((1 << CTRL_BEADS) | (1 << CTRL_BEAD_OUT) | (1 << CTRL_BEAD_VENT));
    localparam logic [CTRL_W-1:0] MASK_CELL    = CTRL_W'((1 << CTRL_CELLS) | (1 << CTRL_CELL_OUT));
    localparam logic [CTRL_W-1:0] MASK_LYSIS   = CTRL_W'((1 << CTRL_LYSIS_IN) | (1 << CTRL_CHAMBER_OUT) | (1 << CTRL_LYSIS_OUT));
    localparam logic [CTRL_W-1:0] MASK_MIX     = CTRL_W'(1 << CTRL_MIX_ISO);
    localparam logic [CTRL_W-1:0] MASK_SEP     = CTRL_W'((1 << CTRL_MAG_IN) | (1 << CTRL_SEP_WASTE) | (1 << CTRL_SEP_IN));
    localparam logic [CTRL_W-1:0] MASK_COLLECT = CTRL_W'((1 << CTRL_COLLECT) | (1 << CTRL_CHAMBER_OUT));

    // Element 0 is the first step after MIX entry.
    localparam logic [5:0][2:0] PUMP_PAT = {3'b101, 3'b001, 3'b011, 3'b010, 3'b110, 3'b100};

    localparam logic [2:0] DUR_BEAD    = 3'd0;
    localparam logic [2:0] DUR_CELL    = 3'd1;
    localparam logic [2:0] DUR_LYSIS   = 3'd2;
    localparam logic [2:0] DUR_MIX     = 3'd3;
    localparam logic [2:0] DUR_SEP     = 3'd4;
    localparam logic [2:0] DUR_COLLECT = 3'd5;

    function automatic logic [CTRL_W-1:0] state_mask(input state_t s);
        case (s)
            ST_BEAD:    return MASK_BEAD;
            ST_CELL:    return MASK_CELL;
            ST_LYSIS:   return MASK_LYSIS;
            ST_MIX:     return MASK_MIX;
            ST_SEP:     return MASK_SEP;
            ST_COLLECT: return MASK_COLLECT;
            default:    return '0;
        endcase
    endfunction

endpackage

// File: rtl/mrnaiso_pump_seq.sv
// Peristaltic pump pattern generator: steps the 6-entry pattern every
// PUMP_DIV cycles while enabled, restarting at step 0 on each enable rise.
module mrnaiso_pump_seq import mrnaiso_pkg::*; #(
    parameter int PUMP_DIV = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    output logic [2:0] pump
);
    localparam int DIV_W = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;

    logic             run;
    logic [DIV_W-1:0] div, div_nxt;
    logic [2:0]       step, step_nxt;

    always_comb begin
        step_nxt = step;
        div_nxt  = div;
        if (!run) begin
            step_nxt = '0;
            div_nxt  = '0;
        end else if (div == DIV_W'(PUMP_DIV - 1)) begin
            div_nxt  = '0;
            step_nxt = (step == 3'd5) ? 3'd0 : step + 3'd1;
        end else begin
            div_nxt = div + 1'b1;
        end
    end

    // pump is registered from the step being entered, so it lines up with
    // the rest of the registered outputs driven from next-state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run  <= 1'b0;
            div  <= '0;
            step <= '0;
            pump <= '0;
        end else if (!enable) begin
            run  <= 1'b0;
            div  <= '0;
            step <= '0;
            pump <= '0;
        end else begin
            run  <= 1'b1;
            div  <= div_nxt;
            step <= step_nxt;
            pump <= PUMP_PAT[step_nxt];
        end
    end
endmodule

// File: rtl/mrnaiso_protocol_seq.sv
// Valve/pump/flush sequencer for one mRNA-isolation chip group. All outputs
// are registered from the next-state decode so they change with the phase.
module mrnaiso_protocol_seq import mrnaiso_pkg::*; #(
    parameter int CTRL_SIZE   = 13,
    parameter int PUMP_SIZE   = 3,
    parameter int FLUSH_SIZE  = 14,
    parameter int DUR_W       = 16,
    parameter int DEFAULT_DUR = 1000,
    parameter int PUMP_DIV    = 50,
    parameter int FLUSH_DWELL = 200
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  cfg_we,
    input  logic [2:0]            cfg_addr,
    input  logic [DUR_W-1:0]      cfg_data,
    output logic                  cfg_err,
    output logic [CTRL_SIZE-1:0]  ctrl,
    output logic [PUMP_SIZE-1:0]  pump,
    output logic [FLUSH_SIZE-1:0] flush,
    output logic                  busy,
    output logic                  done,
    output logic [3:0]            phase
);
    localparam int FIDX_W = (FLUSH_SIZE > 1) ? $clog2(FLUSH_SIZE) : 1;
    localparam int FDW_W  = (FLUSH_DWELL > 1) ? $clog2(FLUSH_DWELL) : 1;

    state_t                        state, state_nxt;
    logic [NUM_DUR-1:0][DUR_W-1:0] dur_q;
    logic [DUR_W-1:0]              cnt, cnt_nxt, bead_load;
    logic [FIDX_W-1:0]             fidx, fidx_nxt;
    logic [FDW_W-1:0]              fdw, fdw_nxt;
    logic [2:0]                    next_idx;
    logic                          cfg_ok;

    function automatic logic [DUR_W-1:0] clamp_dur(input logic [DUR_W-1:0] d);
        return (d == '0) ? DUR_W'(1) : d;
    endfunction

    assign cfg_ok    = cfg_we && (state == ST_IDLE) && (cfg_addr < 3'(NUM_DUR));
    // A write landing with start must already govern the BEAD phase.
    assign bead_load = (cfg_ok && cfg_addr == DUR_BEAD) ? cfg_data : dur_q[DUR_BEAD];
    // Timed state codes are one above their duration index.
    assign next_idx  = state[2:0];
    assign phase     = state;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        fidx_nxt  = fidx;
        fdw_nxt   = fdw;
        if (abort) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            fidx_nxt  = '0;
            fdw_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    state_nxt = ST_BEAD;
                    cnt_nxt   = clamp_dur(bead_load);
                end
                ST_BEAD, ST_CELL, ST_LYSIS, ST_MIX, ST_SEP, ST_COLLECT: begin
                    if (cnt > DUR_W'(1)) begin
                        cnt_nxt = cnt - 1'b1;
                    end else begin
                        state_nxt = state + 4'd1;
                        cnt_nxt   = (state == ST_COLLECT) ? '0 : clamp_dur(dur_q[next_idx]);
                        fidx_nxt  = '0;
                        fdw_nxt   = '0;
                    end
                end
                ST_FLUSH: begin
                    if (fdw == FDW_W'(FLUSH_DWELL - 1)) begin
                        fdw_nxt = '0;
                        if (fidx == FIDX_W'(FLUSH_SIZE - 1)) state_nxt = ST_DONE;
                        else                                  fidx_nxt  = fidx + 1'b1;
                    end else begin
                        fdw_nxt = fdw + 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            fidx    <= '0;
            fdw     <= '0;
            dur_q   <= {NUM_DUR{DUR_W'(DEFAULT_DUR)}};
            ctrl    <= '0;
            flush   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            fidx    <= fidx_nxt;
            fdw     <= fdw_nxt;
            if (cfg_ok) dur_q[cfg_addr] <= cfg_data;
            cfg_err <= cfg_we && !cfg_ok;
            ctrl    <= CTRL_SIZE'(state_mask(state_nxt));
            flush   <= (state_nxt == ST_FLUSH) ? (FLUSH_SIZE'(1) << fidx_nxt) : '0;
            busy    <= (state_nxt != ST_IDLE);
            done    <= (state_nxt == ST_DONE);
        end
    end

    mrnaiso_pump_seq #(.PUMP_DIV(PUMP_DIV)) u_pump (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (state_nxt == ST_MIX),
        .pump   (pump)
    );
endmodule
